acc_frame_reduce: RTL and testbench

Signed frame accumulator placed directly downstream of the generated adder-tree stage. Each valid cycle it takes one reduced partial sum and adds it into a running total. After `LEN` valid samples it emits the frame sum on a valid/ready output register and restarts. This turns per-cycle partial dot products into full-length results for the next layer.

---
 rtl/acc_frame_reduce.sv | 95 +++++++++
 tb/tb_acc_frame_reduce.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/acc_frame_reduce.sv
// Signed frame accumulator: sums LEN valid partial sums and presents the total on a
// valid/ready output register. Optional ACC_SAT_EN clamps the result when OUT_W < ACC_W.
module acc_frame_reduce #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16,
  parameter int LEN   = 4,
  localparam int CNT_W = $clog2(LEN),
  localparam int ACC_W = IN_W + CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_valid,
  input  logic             i_clear,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_overrun,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sext;
  logic signed [ACC_W-1:0] sum;
  logic signed [OUT_W-1:0] conv;
  logic                    done;
  logic                    state;

  assign sext = {{CNT_W{i_data[IN_W-1]}}, i_data};
  assign sum  = acc + sext;
  // A clear forces the current sample to slot 0, so it can never complete a frame.
  assign done = i_valid && !i_clear && (cnt == CNT_W'(LEN - 1));

  generate
    if (OUT_W >= ACC_W) begin : g_ext
      assign conv = OUT_W'(sum);
    end else begin : g_narrow
`ifdef ACC_SAT_EN
      localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      always_comb begin
        conv = sum[OUT_W-1:0];
        if (sum > SMAX)      conv = SMAX[OUT_W-1:0];
        else if (sum < SMIN) conv = SMIN[OUT_W-1:0];
      end
`else
      assign conv = sum[OUT_W-1:0];
`endif
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (i_clear) begin
      cnt <= i_valid ? CNT_W'(1) : '0;
      acc <= i_valid ? sext : '0;
    end else if (i_valid) begin
      if (cnt == '0) begin
        cnt <= CNT_W'(1);
        acc <= sext;
      end else if (done) begin
        cnt <= '0;
        acc <= sum;
      end else begin
        cnt <= cnt + CNT_W'(1);
        acc <= sum;
      end
    end
  end

  // Output holding register; a completion while FULL and not drained overwrites.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= EMPTY;
      o_data    <= '0;
      o_overrun <= 1'b0;
    end else if (done) begin
      o_data <= conv;
      state  <= FULL;
      if (state == FULL && !i_ready) o_overrun <= 1'b1;
    end else if (state == FULL && i_ready) begin
      state <= EMPTY;
    end
  end

  assign o_valid = state;
  assign o_cnt   = cnt;

endmodule

// File: tb/tb_acc_frame_reduce.sv
// Directed bench for acc_frame_reduce: wide (OUT_W=16) and narrow (OUT_W=12) instances
// share stimulus; narrow expectations follow ACC_SAT_EN.
module tb_acc_frame_reduce;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [11:0] i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_ready = 1'b1;

  logic [15:0] w_data;
  logic        w_valid, w_ovr;
  logic [1:0]  w_cnt;
  logic [11:0] n_data;
  logic        n_valid, n_ovr;
  logic [1:0]  n_cnt;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  acc_frame_reduce #(.IN_W(12), .OUT_W(16), .LEN(4)) u_wide (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
    .i_clear(i_clear), .o_data(w_data), .o_valid(w_valid), .i_ready(i_ready),
    .o_overrun(w_ovr), .o_cnt(w_cnt));

  acc_frame_reduce #(.IN_W(12), .OUT_W(12), .LEN(4)) u_narrow (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_valid(i_valid),
    .i_clear(i_clear), .o_data(n_data), .o_valid(n_valid), .i_ready(i_ready),
    .o_overrun(n_ovr), .o_cnt(n_cnt));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, then sample 1 time unit after the rising edge.
  task automatic push(input logic v, input int d, input logic clr = 1'b0);
    i_valid = v;
    i_data  = 12'(d);
    i_clear = clr;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_data", int'($signed(w_data)), 0);
    chk("rst_valid", int'(w_valid), 0);
    chk("rst_ovr", int'(w_ovr), 0);
    chk("rst_cnt", int'(w_cnt), 0);
    chk("rst_n_cnt", int'(n_cnt), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // 1: basic frame, latency and drain
    push(1, 100);
    push(1, 200);
    chk("t1_cnt2", int'(w_cnt), 2);
    push(1, -50);
    chk("t1_valid_pre", int'(w_valid), 0);
    push(1, 7);
    chk("t1_valid", int'(w_valid), 1);
    chk("t1_data", int'($signed(w_data)), 257);
    chk("t1_cnt_wrap", int'(w_cnt), 0);
    push(0, 0);
    chk("t1_drain", int'(w_valid), 0);

    // 2: narrow output, wrap or saturate
    repeat (4) push(1, 2047);
    chk("t2_wide_pos", int'($signed(w_data)), 8188);
`ifdef ACC_SAT_EN
    chk("t2_narrow_pos", int'($signed(n_data)), 2047);
`else
    chk("t2_narrow_pos", int'($signed(n_data)), -4);
`endif
    push(0, 0);
    repeat (4) push(1, -2048);
    chk("t2_wide_neg", int'($signed(w_data)), -8192);
`ifdef ACC_SAT_EN
    chk("t2_narrow_neg", int'($signed(n_data)), -2048);
`else
    chk("t2_narrow_neg", int'($signed(n_data)), 0);
`endif
    push(0, 0);

    // 3: overrun with downstream stalled
    i_ready = 1'b0;
    repeat (4) push(1, 1);
    chk("t3_first_data", int'($signed(w_data)), 4);
    chk("t3_first_ovr", int'(w_ovr), 0);
    repeat (4) push(1, 2);
    chk("t3_data", int'($signed(w_data)), 8);
    chk("t3_valid", int'(w_valid), 1);
    chk("t3_ovr", int'(w_ovr), 1);
    i_ready = 1'b1;
    push(0, 0);
    chk("t3_drain", int'(w_valid), 0);
    push(0, 0);
    chk("t3_ovr_sticky", int'(w_ovr), 1);

    // 4: clear with a coincident sample restarts the frame
    push(1, 5);
    push(1, 5);
    chk("t4_cnt2", int'(w_cnt), 2);
    push(1, 3, 1'b1);
    chk("t4_cnt_clr", int'(w_cnt), 1);
    push(1, 1);
    push(1, 1);
    chk("t4_no_result", int'(w_valid), 0);
    push(1, 1);
    chk("t4_valid", int'(w_valid), 1);
    chk("t4_data", int'($signed(w_data)), 6);
    chk("t4_cnt", int'(w_cnt), 0);
    push(0, 0);

    // 5: asynchronous reset mid-frame
    push(1, 10);
    push(1, 20);
    push(1, 30);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("t5_data", int'($signed(w_data)), 0);
    chk("t5_valid", int'(w_valid), 0);
    chk("t5_ovr", int'(w_ovr), 0);
    chk("t5_cnt", int'(w_cnt), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    push(1, 1);
    push(1, 2);
    push(1, 3);
    push(1, 4);
    chk("t5_after", int'($signed(w_data)), 10);
    chk("t5_after_valid", int'(w_valid), 1);

    // 6: back-to-back frames with gaps 1,0,1,1,0,1
    push(1, 1);
    chk("t6_drop", int'(w_valid), 0);
    push(0, 0);
    push(1, 2);
    push(1, 3);
    push(0, 0);
    chk("t6_hold_cnt", int'(w_cnt), 3);
    push(1, 4);
    chk("t6_f1_valid", int'(w_valid), 1);
    chk("t6_f1_data", int'($signed(w_data)), 10);
    push(1, -1);
    chk("t6_f1_drain", int'(w_valid), 0);
    push(0, 0);
    push(1, -2);
    push(1, -3);
    push(0, 0);
    chk("t6_f2_pre", int'(w_valid), 0);
    push(1, -4);
    chk("t6_f2_valid", int'(w_valid), 1);
    chk("t6_f2_data", int'($signed(w_data)), -10);
    chk("t6_ovr", int'(w_ovr), 0);
    push(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
